// File: rtl/game_pkg.sv
// Shared encodings for the reaction-game turn scheduler: FSM states, winner codes,
// score/round widths and small score helpers.
package game_pkg;

  localparam int SCORE_W = 8;
  localparam int ROUND_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] pick_winner(input logic [SCORE_W-1:0] s0,
                                             input logic [SCORE_W-1:0] s1);
    if (s0 > s1) return WIN_P0;
    if (s1 > s0) return WIN_P1;
    return WIN_TIE;
  endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Signal bundle between the game front end (buttons, ms100 tick, countdown timer) and turn_scheduler.
// Scoring signals exist only when TURN_SCORE_EN is defined.
interface turn_scheduler_if;
  import game_pkg::*;

  // Every input is a one-cycle pulse with no backpressure: a pulse is consumed on the
  // clock edge it is seen at, and all outputs are registered levels (turnStart is a pulse).
  logic               startBtn;
  logic               abortBtn;
  logic               ms100;
  logic               timerStop;
  logic               timerEnable;
  logic               player;
  logic [ROUND_W-1:0] round;
  logic               turnStart;
  logic               busy;
  logic               gameOver;
  state_t             state;
`ifdef TURN_SCORE_EN
  logic               hit;
  logic [SCORE_W-1:0] score0;
  logic [SCORE_W-1:0] score1;
  logic [1:0]         winner;

  modport master (
    output startBtn, abortBtn, ms100, timerStop, hit,
    input  timerEnable, player, round, turnStart, busy, gameOver, state,
           score0, score1, winner
  );
  modport slave (
    input  startBtn, abortBtn, ms100, timerStop, hit,
    output timerEnable, player, round, turnStart, busy, gameOver, state,
           score0, score1, winner
  );
`else
  modport master (
    output startBtn, abortBtn, ms100, timerStop,
    input  timerEnable, player, round, turnStart, busy, gameOver, state
  );
  modport slave (
    input  startBtn, abortBtn, ms100, timerStop,
    output timerEnable, player, round, turnStart, busy, gameOver, state
  );
`endif

endinterface

// File: rtl/turn_gap_timer.sv
// Counts ms100 ticks from a clear; o_done pulses on the tick that completes GAP_TICKS.
module turn_gap_timer #(
  parameter int GAP_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_done
);

  localparam int CNT_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GAP_TICKS - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_done = i_tick && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_done) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// Two-player turn scheduler sharing one countdown timer over NUM_ROUNDS rounds with a gap between turns.
// Define TURN_SCORE_EN to add per-player hit scores and a winner decision.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int NUM_ROUNDS = 3,
  parameter int GAP_TICKS  = 20
) (
  input logic             clk,
  input logic             rst,
  turn_scheduler_if.slave bus
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  state_t             r_state;
  state_t             w_state;
  logic               r_en;
  logic               w_en;
  logic               r_player;
  logic               w_player;
  logic [ROUND_W-1:0] r_round;
  logic [ROUND_W-1:0] w_round;
  logic               r_ts;
  logic               w_ts;
  logic               r_busy;
  logic               w_busy;
  logic               r_go;
  logic               w_go;
  logic               w_gap_clear;
  logic               w_gap_tick;
  logic               w_gap_done;
`ifdef TURN_SCORE_EN
  logic [SCORE_W-1:0] r_score0;
  logic [SCORE_W-1:0] w_score0;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] w_score1;
  logic [1:0]         r_winner;
  logic [1:0]         w_winner;
`endif

  // Counter held clear outside GAP so a tick in the GAP entry cycle already counts.
  assign w_gap_clear = (r_state != ST_GAP);
  assign w_gap_tick  = bus.ms100 && (r_state == ST_GAP);

  turn_gap_timer #(.GAP_TICKS(GAP_TICKS)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_gap_clear),
    .i_tick  (w_gap_tick),
    .o_done  (w_gap_done)
  );

  always_comb begin
    w_state  = r_state;
    w_en     = r_en;
    w_player = r_player;
    w_round  = r_round;
    w_ts     = 1'b0;
`ifdef TURN_SCORE_EN
    w_score0 = r_score0;
    w_score1 = r_score1;
    w_winner = r_winner;
`endif
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.startBtn) begin
          w_state  = ST_PLAY;
          w_player = 1'b0;
          w_round  = '0;
          w_en     = 1'b1;
          w_ts     = 1'b1;
`ifdef TURN_SCORE_EN
          w_score0 = '0;
          w_score1 = '0;
          w_winner = WIN_NONE;
`endif
        end
      end
      ST_PLAY: begin
        if (bus.abortBtn) begin
          w_state = ST_DONE;
          w_en    = 1'b0;
        end else begin
`ifdef TURN_SCORE_EN
          if (bus.hit) begin
            if (r_player) w_score1 = sat_inc(r_score1);
            else          w_score0 = sat_inc(r_score0);
          end
`endif
          if (bus.timerStop) begin
            w_state = ST_GAP;
            w_en    = 1'b0;
          end
        end
      end
      ST_GAP: begin
        if (bus.abortBtn) begin
          w_state = ST_DONE;
          w_en    = 1'b0;
        end else if (w_gap_done) begin
          if (r_player && (r_round == LAST_ROUND)) begin
            w_state = ST_DONE;
            w_en    = 1'b0;
`ifdef TURN_SCORE_EN
            w_winner = pick_winner(r_score0, r_score1);
`endif
          end else begin
            w_state  = ST_PLAY;
            w_player = ~r_player;
            if (r_player) w_round = r_round + 1'b1;
            w_en     = 1'b1;
            w_ts     = 1'b1;
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
    w_busy = (w_state == ST_PLAY) || (w_state == ST_GAP);
    w_go   = (w_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_en     <= 1'b0;
      r_player <= 1'b0;
      r_round  <= '0;
      r_ts     <= 1'b0;
      r_busy   <= 1'b0;
      r_go     <= 1'b0;
`ifdef TURN_SCORE_EN
      r_score0 <= '0;
      r_score1 <= '0;
      r_winner <= WIN_NONE;
`endif
    end else begin
      r_state  <= w_state;
      r_en     <= w_en;
      r_player <= w_player;
      r_round  <= w_round;
      r_ts     <= w_ts;
      r_busy   <= w_busy;
      r_go     <= w_go;
`ifdef TURN_SCORE_EN
      r_score0 <= w_score0;
      r_score1 <= w_score1;
      r_winner <= w_winner;
`endif
    end
  end

  assign bus.state       = r_state;
  assign bus.timerEnable = r_en;
  assign bus.player      = r_player;
  assign bus.round       = r_round;
  assign bus.turnStart   = r_ts;
  assign bus.busy        = r_busy;
  assign bus.gameOver    = r_go;
`ifdef TURN_SCORE_EN
  assign bus.score0      = r_score0;
  assign bus.score1      = r_score1;
  assign bus.winner      = r_winner;
`endif

endmodule
